// File: rtl/instruction_execute_if.sv
// Decode-to-execute bundle: ID/EX register fields in, EX/MEM register fields and stall out.
interface instruction_execute_if;
  logic [1:0]  writeBackControl;
  logic [2:0]  memAccessControl;
  logic [3:0]  calculationControl;
  logic [31:0] programCounterIn;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic [31:0] immediateOperand;
  logic [4:0]  writeRegister0;
  logic [4:0]  writeRegister1;

  logic [1:0]  writeBackControlOut;
  logic [2:0]  memAccessControlOut;
  logic [31:0] branchTarget;
  logic [31:0] aluResult;
  logic        zero;
  logic [31:0] storeData;
  logic [4:0]  writeRegisterOut;
  logic        stall;

  modport master (
    output writeBackControl, memAccessControl, calculationControl, programCounterIn,
           readData1, readData2, immediateOperand, writeRegister0, writeRegister1,
    input  writeBackControlOut, memAccessControlOut, branchTarget, aluResult, zero,
           storeData, writeRegisterOut, stall
  );

  modport slave (
    input  writeBackControl, memAccessControl, calculationControl, programCounterIn,
           readData1, readData2, immediateOperand, writeRegister0, writeRegister1,
    output writeBackControlOut, memAccessControlOut, branchTarget, aluResult, zero,
           storeData, writeRegisterOut, stall
  );
endinterface

// File: rtl/instruction_execute.sv
// Execute stage: ALU, branch target, destination select and EX/MEM register,
// with a 32-iteration shift-add multiplier that stalls upstream while busy.
module instruction_execute (
  input  logic               clk,
  input  logic               reset,
  instruction_execute_if.slave ex
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      r_state;
  logic [4:0]  r_count;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [31:0] r_acc;

  logic [1:0]  r_wbOut;
  logic [2:0]  r_memOut;
  logic [31:0] r_branchTarget;
  logic [31:0] r_aluResult;
  logic        r_zero;
  logic [31:0] r_storeData;
  logic [4:0]  r_writeRegOut;

  logic        w_regDst;
  logic [1:0]  w_aluOp;
  logic        w_aluSrc;
  logic [5:0]  w_funct;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [31:0] w_alu;
  logic        w_isMult;
  logic        w_stall;
  logic [31:0] w_branchTarget;
  logic [4:0]  w_writeReg;

  assign w_regDst       = ex.calculationControl[3];
  assign w_aluOp        = ex.calculationControl[2:1];
  assign w_aluSrc       = ex.calculationControl[0];
  assign w_funct        = ex.immediateOperand[5:0];
  assign w_a            = ex.readData1;
  assign w_b            = w_aluSrc ? ex.immediateOperand : ex.readData2;
  assign w_isMult       = (w_aluOp == 2'b10) && (w_funct == 6'h18);
  assign w_stall        = w_isMult && (r_state != DONE);
  assign w_branchTarget = ex.programCounterIn + {ex.immediateOperand[29:0], 2'b00};
  assign w_writeReg     = w_regDst ? ex.writeRegister1 : ex.writeRegister0;

  always_comb begin
    w_alu = '0;
    case (w_aluOp)
      2'b00: w_alu = w_a + w_b;
      2'b01: w_alu = w_a - w_b;
      2'b11: w_alu = w_a & w_b;
      default: begin
        case (w_funct)
          6'h20:   w_alu = w_a + w_b;
          6'h22:   w_alu = w_a - w_b;
          6'h24:   w_alu = w_a & w_b;
          6'h25:   w_alu = w_a | w_b;
          6'h2A:   w_alu = ($signed(w_a) < $signed(w_b)) ? 32'd1 : 32'd0;
          default: w_alu = '0;  // mult result comes from the accumulator path
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_count        <= '0;
      r_mcand        <= '0;
      r_mplier       <= '0;
      r_acc          <= '0;
      r_wbOut        <= '0;
      r_memOut       <= '0;
      r_branchTarget <= '0;
      r_aluResult    <= '0;
      r_zero         <= 1'b0;
      r_storeData    <= '0;
      r_writeRegOut  <= '0;
    end else begin
      // Bubble downstream while the multiply holds the pipeline.
      if (w_stall) begin
        r_wbOut  <= '0;
        r_memOut <= '0;
      end
      case (r_state)
        IDLE: begin
          if (w_isMult) begin
            r_mcand  <= w_a;
            r_mplier <= ex.readData2;
            r_acc    <= '0;
            r_count  <= '0;
            r_state  <= BUSY;
          end else begin
            r_wbOut        <= ex.writeBackControl;
            r_memOut       <= ex.memAccessControl;
            r_branchTarget <= w_branchTarget;
            r_aluResult    <= w_alu;
            r_zero         <= (w_alu == '0);
            r_storeData    <= ex.readData2;
            r_writeRegOut  <= w_writeReg;
          end
        end
        BUSY: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= {r_mcand[30:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[31:1]};
          r_count  <= r_count + 5'd1;
          if (r_count == 5'd31) r_state <= DONE;
        end
        DONE: begin
          r_wbOut        <= ex.writeBackControl;
          r_memOut       <= ex.memAccessControl;
          r_branchTarget <= w_branchTarget;
          r_aluResult    <= r_acc;
          r_zero         <= (r_acc == '0);
          r_storeData    <= ex.readData2;
          r_writeRegOut  <= w_writeReg;
          r_state        <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ex.writeBackControlOut = r_wbOut;
  assign ex.memAccessControlOut = r_memOut;
  assign ex.branchTarget        = r_branchTarget;
  assign ex.aluResult           = r_aluResult;
  assign ex.zero                = r_zero;
  assign ex.storeData           = r_storeData;
  assign ex.writeRegisterOut    = r_writeRegOut;
  assign ex.stall               = w_stall;
endmodule

// File: tb/tb_instruction_execute.sv
// Scoreboard bench for the execute stage: driver pushes model results, monitor compares per edge.
module tb_instruction_execute;
  typedef struct packed {
    logic [1:0]  wb;
    logic [2:0]  mem;
    logic [3:0]  calc;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } instr_t;

  typedef struct packed {
    logic [1:0]  wb;
    logic [2:0]  mem;
    logic [31:0] bt;
    logic [31:0] alu;
    logic        zero;
    logic [31:0] sd;
    logic [4:0]  wr;
  } out_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en = 1'b0;
  out_t exp_q[$];
  out_t exp_prev = '0;

  instruction_execute_if bus();
  instruction_execute dut (.clk(clk), .reset(reset), .ex(bus));

  always #5 clk = ~clk;

  function automatic bit is_mult(input instr_t t);
    return (t.calc[2:1] == 2'b10) && (t.imm[5:0] == 6'h18);
  endfunction

  function automatic out_t model(input instr_t t);
    out_t        o;
    logic [31:0] bop;
    logic [31:0] r;
    logic [63:0] prod;
    bop  = t.calc[0] ? t.imm : t.b;
    prod = {32'd0, t.a} * {32'd0, t.b};
    case (t.calc[2:1])
      2'd0: r = t.a + bop;
      2'd1: r = t.a - bop;
      2'd3: r = t.a & bop;
      default: begin
        case (t.imm[5:0])
          6'h20:   r = t.a + bop;
          6'h22:   r = t.a - bop;
          6'h24:   r = t.a & bop;
          6'h25:   r = t.a | bop;
          6'h2A:   r = ($signed(t.a) < $signed(bop)) ? 32'd1 : 32'd0;
          6'h18:   r = prod[31:0];
          default: r = 32'd0;
        endcase
      end
    endcase
    o.wb   = t.wb;
    o.mem  = t.mem;
    o.bt   = t.pc + t.imm * 32'd4;
    o.alu  = r;
    o.zero = (r == 32'd0);
    o.sd   = t.b;
    o.wr   = t.calc[3] ? t.rd : t.rt;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic check_out(input string tag, input out_t e);
    chk({tag, ".wb"},   {30'd0, bus.writeBackControlOut}, {30'd0, e.wb});
    chk({tag, ".mem"},  {29'd0, bus.memAccessControlOut}, {29'd0, e.mem});
    chk({tag, ".bt"},   bus.branchTarget, e.bt);
    chk({tag, ".alu"},  bus.aluResult, e.alu);
    chk({tag, ".zero"}, {31'd0, bus.zero}, {31'd0, e.zero});
    chk({tag, ".sd"},   bus.storeData, e.sd);
    chk({tag, ".wr"},   {27'd0, bus.writeRegisterOut}, {27'd0, e.wr});
  endtask

  task automatic drive(input instr_t t);
    bus.writeBackControl   = t.wb;
    bus.memAccessControl   = t.mem;
    bus.calculationControl = t.calc;
    bus.programCounterIn   = t.pc;
    bus.readData1          = t.a;
    bus.readData2          = t.b;
    bus.immediateOperand   = t.imm;
    bus.writeRegister0     = t.rt;
    bus.writeRegister1     = t.rd;
  endtask

  // Called at a falling edge; holds the instruction until an edge with stall low, returns at a falling edge.
  task automatic issue(input instr_t t);
    int unsigned n_stall = 0;
    bit          accepted = 1'b0;
    logic        s;
    drive(t);
    exp_q.push_back(model(t));
    for (int c = 0; c < 40 && !accepted; c++) begin
      #2 s = bus.stall;
      @(posedge clk);
      if (!s) accepted = 1'b1;
      else n_stall++;
      @(negedge clk);
    end
    if (!accepted) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout actual=stalled expected=accepted t=%0t", $time);
    end
    chk("stall_cycles", n_stall, is_mult(t) ? 32'd33 : 32'd0);
  endtask

  initial begin : monitor
    logic s;
    out_t e;
    forever begin
      @(negedge clk);
      #2 s = bus.stall;
      @(posedge clk);
      #1;
      if (mon_en && !reset) begin
        if (!s) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_accept actual=accept expected=none t=%0t", $time);
          end else begin
            e = exp_q.pop_front();
            exp_prev = e;
            check_out("result", e);
          end
        end else begin
          e = exp_prev;
          e.wb  = '0;
          e.mem = '0;
          exp_prev = e;
          check_out("bubble", e);
        end
      end
    end
  end

  function automatic instr_t mk(input logic [3:0] calc, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] imm, input logic [31:0] pc);
    instr_t t;
    t.wb   = 2'($urandom);
    t.mem  = 3'($urandom);
    t.calc = calc;
    t.pc   = pc;
    t.a    = a;
    t.b    = b;
    t.imm  = imm;
    t.rt   = 5'($urandom);
    t.rd   = 5'($urandom);
    return t;
  endfunction

  initial begin : stimulus
    instr_t t;
    instr_t tm;
    logic [5:0] functs [6];
    functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h3F};
    drive('0);

    #3;
    check_out("reset", '0);
    chk("reset.stall", {31'd0, bus.stall}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;

    issue(mk(4'b0001, 32'd5, 32'h0, 32'hFFFF_FFFF, 32'h40));
    issue(mk(4'b0010, 32'h1234, 32'h1234, 32'd3, 32'h100));
    issue(mk(4'b1100, 32'hFFFF_FFFF, 32'd1, 32'h2A, 32'h8));
    issue(mk(4'b1100, 32'hF0, 32'h0F, 32'h25, 32'hC));
    issue(mk(4'b1100, 32'h55, 32'h0F, 32'h3F, 32'h10));
    t = mk(4'b1100, 32'd1, 32'd2, 32'h20, 32'h14);
    t.rt = 5'd7;
    t.rd = 5'd12;
    issue(t);
    t.calc = 4'b0100;
    issue(t);

    tm = mk(4'b1100, 32'h0001_0003, 32'h0002_0005, 32'h18, 32'h200);
    tm.wb  = 2'b11;
    tm.mem = 3'b101;
    issue(tm);
    issue(mk(4'b1100, 32'hDEAD_BEEF, 32'h1357_9BDF, 32'h18, 32'h204));
    issue(mk(4'b1100, 32'h0, 32'h1234_5678, 32'h18, 32'h208));
    issue(mk(4'b0000, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h20C));

    // Reset lands while the multiplier is mid-sequence.
    mon_en = 1'b0;
    drive(tm);
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_out("midreset", '0);
    chk("midreset.stall", {31'd0, bus.stall}, 32'd1);
    exp_q.delete();
    exp_prev = '0;
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;
    issue(tm);

    for (int i = 0; i < 80; i++) begin
      t = mk(4'($urandom), $urandom, $urandom, $urandom, $urandom);
      if (t.calc[2:1] == 2'b10) begin
        t.calc[0] = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 7) == 0) t.imm[5:0] = 6'h18;
        else if ($urandom_range(0, 5) != 0) t.imm[5:0] = functs[$urandom_range(0, 5)];
        else if (t.imm[5:0] == 6'h18) t.imm[5:0] = 6'h19;
      end
      if ($urandom_range(0, 5) == 0) t.b = t.calc[0] ? t.imm - t.imm : t.a;
      issue(t);
    end

    mon_en = 1'b0;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
